serial_parity_checker: RTL and testbench

Frame-based serial parity checker that generalises the single-bit even/odd parity detector. It accepts a qualified serial bit stream of `DATA_BITS` data bits followed by one parity bit. Per frame it reports a running parity, a frame-done strobe and a parity-error strobe, and keeps a saturating error count. It sits behind a serial receiver/deserialiser, and its error outputs feed status logic.

---
 rtl/serial_parity_pkg.sv | 21 ++
 rtl/serial_parity_checker_if.sv | 27 ++
 rtl/serial_parity_checker_sat_counter.sv | 38 +++
 rtl/serial_parity_checker.sv | 102 ++++++++++
 tb/tb_serial_parity_checker.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity checker.
//   state_e         : frame state (data bits vs. the trailing parity bit)
//   PAR_EVEN/PAR_ODD: values of the odd_mode input
//   expected_parity : the parity bit a correct frame must carry
package serial_parity_pkg;

  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // par is the XOR of all data bits. A correct parity bit makes the
  // whole frame even (PAR_EVEN) or odd (PAR_ODD).
  function automatic logic expected_parity(input logic par, input logic mode);
    return par ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bus between a serial receiver and the parity checker.
//   master : drives x, x_valid, odd_mode, err_clr; observes the results
//   slave  : the checker; drives z, frame_done, parity_err, err_count, busy
// CNT_W must match the CNT_W of the checker it is connected to.
interface serial_parity_checker_if #(
  parameter int CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic             odd_mode;
  logic             err_clr;
  logic             z;
  logic             frame_done;
  logic             parity_err;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    output x, x_valid, odd_mode, err_clr,
    input  z, frame_done, parity_err, err_count, busy
  );

  modport slave (
    input  x, x_valid, odd_mode, err_clr,
    output z, frame_done, parity_err, err_count, busy
  );
endinterface

// File: rtl/serial_parity_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count up by one, sticking at all-ones
//   clr      : clear; clr together with inc loads 1 so the event is kept
//   count_o  : current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its inputs from before the edge, independent of block order.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Frame-based serial parity checker: DATA_BITS data bits followed by one
// parity bit, one accepted bit per cycle when x_valid is high.
//   clk, rst : clock, synchronous active-high reset (discards a partial frame)
//   bus      : slave side of serial_parity_checker_if
//              z          registered running XOR of this frame's data bits
//              frame_done one-cycle pulse after the parity bit is accepted
//              parity_err pulse with frame_done when the parity bit is wrong
//              err_count  saturating count of bad frames, cleared by err_clr
//              busy       a frame is in progress
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_parity_checker_if.slave  bus
);

  localparam int             CW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  LAST = CW'(DATA_BITS - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           par_q, par_d;
  logic           mode_lat_q, mode_lat_d;
  logic           z_q, z_d;
  logic           frame_done_q, frame_done_d;
  logic           parity_err_q, parity_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    mode_lat_d   = mode_lat_q;
    z_d          = z_q;
    frame_done_d = 1'b0;
    parity_err_d = 1'b0;

    if (bus.x_valid) begin
      unique case (state_q)
        S_DATA: begin
          par_d     = par_q ^ bus.x;
          z_d       = par_q ^ bus.x;
          bit_cnt_d = bit_cnt_q + CW'(1);
          // Mode is sampled on data bit 0 only; later changes are ignored.
          if (bit_cnt_q == '0) mode_lat_d = bus.odd_mode;
          // With DATA_BITS=1, LAST is 0 and bit 0 goes straight to parity.
          if (bit_cnt_q == LAST) state_d = S_PARITY;
        end
        S_PARITY: begin
          frame_done_d = 1'b1;
          parity_err_d = (bus.x != expected_parity(par_q, mode_lat_q));
          par_d        = 1'b0;
          z_d          = 1'b0;
          bit_cnt_d    = '0;
          state_d      = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_DATA;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      mode_lat_q   <= PAR_EVEN;
      z_q          <= 1'b0;
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      mode_lat_q   <= mode_lat_d;
      z_q          <= z_d;
      frame_done_q <= frame_done_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Driven from the combinational error so the count updates on the same
  // edge that registers parity_err.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (parity_err_d),
    .clr     (bus.err_clr),
    .count_o (bus.err_count)
  );

  assign bus.z          = z_q;
  assign bus.frame_done = frame_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = (bit_cnt_q != '0) || (state_q == S_PARITY);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker. Two instances:
//   dut_a : DATA_BITS=8, CNT_W=2 (main frames, saturation at 3)
//   dut_b : DATA_BITS=1, CNT_W=4 (minimum frame)
// The driver pushes the expected post-edge outputs into a queue; a monitor
// per instance pops and compares on the falling edge.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  serial_parity_checker_if #(.CNT_W(2)) if_a ();
  serial_parity_checker_if #(.CNT_W(4)) if_b ();

  serial_parity_checker #(.DATA_BITS(8), .CNT_W(2)) dut_a (
    .clk (clk), .rst (rst_a), .bus (if_a.slave)
  );
  serial_parity_checker #(.DATA_BITS(1), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (if_b.slave)
  );

  typedef struct {
    logic z;
    logic fd;
    logic pe;
    int   cnt;
    logic busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a frame is described by how many data bits it
  // holds, how many of them were ones and the mode seen on its first bit.
  int   nbits[2];
  int   ones[2];
  logic mode[2];
  int   errs[2];

  function automatic int data_bits(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 0) ? 3 : 15;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus for instance d, followed by the model update.
  task automatic step(input int d, input logic r, input logic xb,
                      input logic v, input logic m, input logic c);
    exp_t e;
    logic err;
    if (d == 0) begin
      rst_a = r; if_a.x = xb; if_a.x_valid = v; if_a.odd_mode = m; if_a.err_clr = c;
    end else begin
      rst_b = r; if_b.x = xb; if_b.x_valid = v; if_b.odd_mode = m; if_b.err_clr = c;
    end
    @(posedge clk);
    e.fd = 1'b0;
    e.pe = 1'b0;
    err  = 1'b0;
    if (r) begin
      nbits[d] = 0; ones[d] = 0; mode[d] = 1'b0; errs[d] = 0;
    end else begin
      if (v) begin
        if (nbits[d] < data_bits(d)) begin
          if (nbits[d] == 0) mode[d] = m;
          nbits[d]++;
          ones[d] += int'(xb);
        end else begin
          // Total ones over data + parity must be even (mode 0) or odd (mode 1).
          err = (((ones[d] + int'(xb)) % 2) != int'(mode[d]));
          e.fd = 1'b1;
          e.pe = err;
          nbits[d] = 0;
          ones[d]  = 0;
        end
      end
      if (c)                              errs[d] = err ? 1 : 0;
      else if (err && errs[d] < cnt_max(d)) errs[d]++;
    end
    e.z    = logic'(ones[d] % 2);
    e.cnt  = errs[d];
    e.busy = (nbits[d] != 0);
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends nb data bits (data[0] first) and one parity bit. mode_first goes
  // with data bit 0, mode_rest with everything after. With gaps set, two
  // invalid cycles with toggling x follow every data bit.
  task automatic send_frame(input int d, input logic [7:0] data, input int nb,
                            input logic mode_first, input logic mode_rest,
                            input logic par, input logic clr_on_par,
                            input logic gaps);
    for (int i = 0; i < nb; i++) begin
      step(d, 1'b0, data[i], 1'b1, (i == 0) ? mode_first : mode_rest, 1'b0);
      if (gaps) begin
        step(d, 1'b0, 1'b1, 1'b0, mode_rest, 1'b0);
        step(d, 1'b0, 1'b0, 1'b0, ~mode_rest, 1'b0);
      end
    end
    step(d, 1'b0, par, 1'b1, mode_rest, clr_on_par);
  endtask

  task automatic random_run(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      step(d, ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0));
    end
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_z",          int'(if_a.z),          int'(e.z));
        check("a_frame_done", int'(if_a.frame_done), int'(e.fd));
        check("a_parity_err", int'(if_a.parity_err), int'(e.pe));
        check("a_err_count",  int'(if_a.err_count),  e.cnt);
        check("a_busy",       int'(if_a.busy),       int'(e.busy));
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_z",          int'(if_b.z),          int'(e.z));
        check("b_frame_done", int'(if_b.frame_done), int'(e.fd));
        check("b_parity_err", int'(if_b.parity_err), int'(e.pe));
        check("b_err_count",  int'(if_b.err_count),  e.cnt);
        check("b_busy",       int'(if_b.busy),       int'(e.busy));
      end
    end
  end

  localparam logic [7:0] PATTERN = 8'b1000_1101;  // sent as 1,0,1,1,0,0,0,1

  initial begin
    for (int d = 0; d < 2; d++) begin
      nbits[d] = 0; ones[d] = 0; mode[d] = 1'b0; errs[d] = 0;
    end
    rst_a = 1'b1; if_a.x = 1'b0; if_a.x_valid = 1'b0; if_a.odd_mode = 1'b0; if_a.err_clr = 1'b0;
    rst_b = 1'b1; if_b.x = 1'b0; if_b.x_valid = 1'b0; if_b.odd_mode = 1'b0; if_b.err_clr = 1'b0;
    @(negedge clk);

    // Reset held with a valid 1 on x.
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("a_reset_busy", int'(if_a.busy), 0);

    // Even-mode good frame.
    send_frame(0, PATTERN, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_even_good_cnt", int'(if_a.err_count), 0);

    // Odd-mode bad frame, then the corrected one.
    send_frame(0, PATTERN, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a_odd_bad_err", int'(if_a.parity_err), 1);
    check("a_odd_bad_cnt", int'(if_a.err_count), 1);
    send_frame(0, PATTERN, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("a_odd_good_cnt", int'(if_a.err_count), 1);

    // Valid gaps plus odd_mode flipped after bit 0: still an even good frame.
    send_frame(0, PATTERN, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("a_gap_err", int'(if_a.parity_err), 0);

    // Clear, then saturate a 2-bit counter with 4 bad frames.
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("a_clr_cnt", int'(if_a.err_count), 0);
    for (int k = 0; k < 4; k++) send_frame(0, PATTERN, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("a_sat_cnt", int'(if_a.err_count), 3);
    send_frame(0, PATTERN, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("a_clr_with_err_cnt", int'(if_a.err_count), 1);

    // Reset after 5 data bits, then a full frame from bit 0.
    for (int i = 0; i < 5; i++) step(0, 1'b0, PATTERN[i], 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_midrst_busy", int'(if_a.busy), 0);
    check("a_midrst_z", int'(if_a.z), 0);
    send_frame(0, PATTERN, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_after_rst_done", int'(if_a.frame_done), 1);
    check("a_after_rst_err", int'(if_a.parity_err), 0);

    random_run(0, 600);
    idle(0, 2);

    // Minimum frame: one data bit and its parity.
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'h01, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b_min_done", int'(if_b.frame_done), 1);
    check("b_min_cnt", int'(if_b.err_count), 0);
    send_frame(1, 8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b_min_bad_cnt", int'(if_b.err_count), 1);
    send_frame(1, 8'h01, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b_min_odd_cnt", int'(if_b.err_count), 1);

    random_run(1, 300);
    idle(1, 2);

    @(negedge clk);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
